// File: rtl/dds_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// dds_sweep_ctrl
//
// Frequency-sweep / tone scheduler for a phase-accumulator DDS. A sweep
// profile (start, stop, step, dwell, phase, loop) is captured over a
// valid/ready handshake into shadow registers. A start pulse steps fword from
// the start word toward the stop word. Each word is held for dwell+1 cycles.
// The step computation is one bit wider than FW_WIDTH, so a sweep never wraps
// past the top of the word range.
//
// Optional feature (compile-time macro DDS_SWEEP_TRIANGLE_EN):
//   defined   - at the top of the sweep the direction reverses (RUN_DN),
//               which gives a triangle profile.
//   undefined - the sweep restarts at the start word (sawtooth).
//
// Parameters:
//   FW_WIDTH    - width of the frequency/phase control words
//   DWELL_WIDTH - width of the dwell counter
//
// Ports:
//   clk, rst_n          - clock; asynchronous active-low reset
//   cfg_valid/cfg_ready - config handshake; cfg_ready is high only in IDLE
//   cfg_start/stop/step - sweep start word, upper bound, increment
//   cfg_dwell           - extra hold cycles per word (hold = dwell+1)
//   cfg_pword           - phase word, presented on pword after transfer
//   cfg_loop            - 1 = continuous sweep, 0 = single sweep
//   start, abort        - one-cycle control pulses (abort wins)
//   fword, pword        - registered control words to the DDS core
//   busy                - sweep in progress
//   step_tick           - one-cycle pulse on each fword update in a sweep
//   done                - one-cycle pulse at the end of a single sweep
// -----------------------------------------------------------------------------
module dds_sweep_ctrl #(
   parameter int FW_WIDTH    = 10,
   parameter int DWELL_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   input  logic [FW_WIDTH-1:0]    cfg_start,
   input  logic [FW_WIDTH-1:0]    cfg_stop,
   input  logic [FW_WIDTH-1:0]    cfg_step,
   input  logic [DWELL_WIDTH-1:0] cfg_dwell,
   input  logic [FW_WIDTH-1:0]    cfg_pword,
   input  logic                   cfg_loop,
   input  logic                   start,
   input  logic                   abort,
   output logic [FW_WIDTH-1:0]    fword,
   output logic [FW_WIDTH-1:0]    pword,
   output logic                   busy,
   output logic                   step_tick,
   output logic                   done
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN_UP = 2'd1,
      RUN_DN = 2'd2
   } state_t;

   state_t                 state, state_n;
   logic [FW_WIDTH-1:0]    sh_start, sh_stop, sh_step;
   logic [DWELL_WIDTH-1:0] sh_dwell;
   logic                   sh_loop;
   logic [DWELL_WIDTH-1:0] cnt, cnt_n;
   logic [FW_WIDTH-1:0]    fword_n;
   logic                   busy_n, tick_n, done_n;
   logic                   xfer;
   logic [FW_WIDTH:0]      next_up;
   logic                   up_fits;

   assign cfg_ready = (state == IDLE);
   assign xfer      = cfg_valid && cfg_ready;

   // The extra bit keeps an overflowing step from aliasing to a small word.
   assign next_up = {1'b0, fword} + {1'b0, sh_step};
   assign up_fits = (next_up <= {1'b0, sh_stop});

`ifdef DDS_SWEEP_TRIANGLE_EN
   logic dn_end;
   // The down leg ends when one more step would go below the start word.
   // The compare is widened so that start+step cannot wrap.
   assign dn_end = ({1'b0, fword} < ({1'b0, sh_start} + {1'b0, sh_step}));
`endif

   // Shadow profile registers. pword is the shadow of the phase word itself.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_start <= '0;
         sh_stop  <= '0;
         sh_step  <= '0;
         sh_dwell <= '0;
         sh_loop  <= 1'b0;
         pword    <= '0;
      end else if (xfer) begin
         // NOTE: sequential state uses non-blocking assignments, so every
         // register samples values from before this edge.
         sh_start <= cfg_start;
         sh_stop  <= cfg_stop;
         sh_step  <= cfg_step;
         sh_dwell <= cfg_dwell;
         sh_loop  <= cfg_loop;
         pword    <= cfg_pword;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         fword     <= '0;
         cnt       <= '0;
         busy      <= 1'b0;
         step_tick <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         fword     <= fword_n;
         cnt       <= cnt_n;
         busy      <= busy_n;
         step_tick <= tick_n;
         done      <= done_n;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first. Otherwise a
      // branch that does not assign a signal would infer a latch.
      state_n = state;
      fword_n = fword;
      cnt_n   = cnt;
      busy_n  = busy;
      tick_n  = 1'b0;
      done_n  = 1'b0;

      unique case (state)
         IDLE: begin
            if (start && !abort) begin
               // When a config transfer happens in the same cycle, the sweep
               // takes the new profile straight from the cfg inputs.
               state_n = RUN_UP;
               fword_n = xfer ? cfg_start : sh_start;
               cnt_n   = xfer ? cfg_dwell : sh_dwell;
               busy_n  = 1'b1;
               tick_n  = 1'b1;
            end
         end

         RUN_UP: begin
            if (abort) begin
               state_n = IDLE;
               fword_n = '0;
               busy_n  = 1'b0;
            end else if (cnt != '0) begin
               cnt_n = cnt - DWELL_WIDTH'(1);
            end else if (sh_step == '0) begin
               // Tone mode: hold the start word with no further ticks.
               cnt_n = '0;
            end else if (up_fits) begin
               fword_n = next_up[FW_WIDTH-1:0];
               tick_n  = 1'b1;
               cnt_n   = sh_dwell;
            end else begin
`ifdef DDS_SWEEP_TRIANGLE_EN
               if (!dn_end) begin
                  // Reverse without repeating the top value.
                  state_n = RUN_DN;
                  fword_n = fword - sh_step;
                  tick_n  = 1'b1;
                  cnt_n   = sh_dwell;
               end else if (sh_loop) begin
                  fword_n = sh_start;
                  tick_n  = 1'b1;
                  cnt_n   = sh_dwell;
               end else begin
                  state_n = IDLE;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
               end
`else
               if (sh_loop) begin
                  fword_n = sh_start;
                  tick_n  = 1'b1;
                  cnt_n   = sh_dwell;
               end else begin
                  state_n = IDLE;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
               end
`endif
            end
         end

`ifdef DDS_SWEEP_TRIANGLE_EN
         RUN_DN: begin
            if (abort) begin
               state_n = IDLE;
               fword_n = '0;
               busy_n  = 1'b0;
            end else if (cnt != '0) begin
               cnt_n = cnt - DWELL_WIDTH'(1);
            end else if (dn_end) begin
               if (sh_loop) begin
                  // Turn around at the bottom without repeating it.
                  state_n = RUN_UP;
                  fword_n = up_fits ? next_up[FW_WIDTH-1:0] : fword;
                  tick_n  = 1'b1;
                  cnt_n   = sh_dwell;
               end else begin
                  state_n = IDLE;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
               end
            end else begin
               fword_n = fword - sh_step;
               tick_n  = 1'b1;
               cnt_n   = sh_dwell;
            end
         end
`endif

         default: begin
            state_n = IDLE;
            fword_n = '0;
            busy_n  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dds_sweep_ctrl
//
// Directed testbench for dds_sweep_ctrl. The bench drives inputs and samples
// outputs on the falling clock edge. All expected values are fixed by hand
// from the sweep profile of each test.
// -----------------------------------------------------------------------------
module tb_dds_sweep_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [9:0]  cfg_start, cfg_stop, cfg_step, cfg_pword;
   logic [15:0] cfg_dwell;
   logic        cfg_loop;
   logic        start, abort;
   logic [9:0]  fword, pword;
   logic        busy, step_tick, done;

   int n_checks = 0;
   int n_errors = 0;

   dds_sweep_ctrl #(.FW_WIDTH(10), .DWELL_WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_start (cfg_start),
      .cfg_stop  (cfg_stop),
      .cfg_step  (cfg_step),
      .cfg_dwell (cfg_dwell),
      .cfg_pword (cfg_pword),
      .cfg_loop  (cfg_loop),
      .start     (start),
      .abort     (abort),
      .fword     (fword),
      .pword     (pword),
      .busy      (busy),
      .step_tick (step_tick),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic load_cfg(input logic [9:0] s, input logic [9:0] e,
                           input logic [9:0] st, input logic [15:0] dw,
                           input logic [9:0] pw, input logic lp);
      cfg_start = s;  cfg_stop  = e;  cfg_step = st;
      cfg_dwell = dw; cfg_pword = pw; cfg_loop = lp;
      cfg_valid = 1'b1;
      cyc();
      cfg_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic pulse_abort();
      abort = 1'b1;
      cyc();
      abort = 1'b0;
   endtask

   task automatic test_reset();
      n_checks++;
      if ({fword, pword, busy, step_tick, done, cfg_ready} !== {10'd0, 10'd0, 4'b0001}) begin
         n_errors++;
         $display("FAIL reset: got fword=%0d pword=%0d busy=%b tick=%b done=%b ready=%b, want 0 0 0 0 0 1",
                  fword, pword, busy, step_tick, done, cfg_ready);
      end
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_single_sweep();
      logic [9:0] exp_f;
      logic       exp_t;
      load_cfg(10'd10, 10'd40, 10'd10, 16'd2, 10'd0, 1'b0);
      pulse_start();
      for (int i = 0; i < 12; i++) begin
         exp_f = 10'(10 + 10 * (i / 3));
         exp_t = ((i % 3) == 0);
         n_checks++;
         if (fword !== exp_f || busy !== 1'b1 || step_tick !== exp_t || done !== 1'b0 || cfg_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL single_sweep[%0d]: got fword=%0d busy=%b tick=%b done=%b ready=%b, want fword=%0d busy=1 tick=%b done=0 ready=0",
                     i, fword, busy, step_tick, done, cfg_ready, exp_f, exp_t);
         end
         cyc();
      end
      n_checks++;
      if (fword !== 10'd40 || busy !== 1'b0 || step_tick !== 1'b0 || done !== 1'b1) begin
         n_errors++;
         $display("FAIL single_done: got fword=%0d busy=%b tick=%b done=%b, want 40 0 0 1",
                  fword, busy, step_tick, done);
      end
      cyc();
      n_checks++;
      if (fword !== 10'd40 || busy !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL single_after: got fword=%0d busy=%b done=%b ready=%b, want 40 0 0 1",
                  fword, busy, done, cfg_ready);
      end
   endtask

   task automatic test_no_wrap();
      load_cfg(10'd1000, 10'd1023, 10'd50, 16'd0, 10'd0, 1'b0);
      pulse_start();
      n_checks++;
      if (fword !== 10'd1000 || busy !== 1'b1 || step_tick !== 1'b1 || done !== 1'b0) begin
         n_errors++;
         $display("FAIL no_wrap_first: got fword=%0d busy=%b tick=%b done=%b, want 1000 1 1 0",
                  fword, busy, step_tick, done);
      end
      cyc();
      n_checks++;
      if (fword !== 10'd1000 || busy !== 1'b0 || step_tick !== 1'b0 || done !== 1'b1) begin
         n_errors++;
         $display("FAIL no_wrap_done: got fword=%0d busy=%b tick=%b done=%b, want 1000 0 0 1",
                  fword, busy, step_tick, done);
      end
      cyc();
      n_checks++;
      if (fword !== 10'd1000 || busy !== 1'b0 || done !== 1'b0) begin
         n_errors++;
         $display("FAIL no_wrap_hold: got fword=%0d busy=%b done=%b, want 1000 0 0",
                  fword, busy, done);
      end
   endtask

   task automatic test_continuous();
      logic [9:0] exp_seq [9];
`ifdef DDS_SWEEP_TRIANGLE_EN
      exp_seq = '{10'd0, 10'd10, 10'd20, 10'd10, 10'd0, 10'd10, 10'd20, 10'd10, 10'd0};
`else
      exp_seq = '{10'd0, 10'd10, 10'd20, 10'd0, 10'd10, 10'd20, 10'd0, 10'd10, 10'd20};
`endif
      load_cfg(10'd0, 10'd20, 10'd10, 16'd0, 10'd0, 1'b1);
      pulse_start();
      for (int i = 0; i < 9; i++) begin
         n_checks++;
         if (fword !== exp_seq[i] || busy !== 1'b1 || step_tick !== 1'b1 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL continuous[%0d]: got fword=%0d busy=%b tick=%b done=%b, want fword=%0d busy=1 tick=1 done=0",
                     i, fword, busy, step_tick, done, exp_seq[i]);
         end
         cyc();
      end
      pulse_abort();
      n_checks++;
      if (fword !== 10'd0 || busy !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL continuous_abort: got fword=%0d busy=%b done=%b ready=%b, want 0 0 0 1",
                  fword, busy, done, cfg_ready);
      end
   endtask

   task automatic test_abort();
      logic [9:0] exp_f;
      load_cfg(10'd10, 10'd100, 10'd10, 16'd5, 10'd5, 1'b0);
      pulse_start();
      for (int i = 0; i <= 8; i++) begin
         exp_f = (i < 6) ? 10'd10 : 10'd20;
         n_checks++;
         if (fword !== exp_f || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL abort_dwell[%0d]: got fword=%0d busy=%b, want fword=%0d busy=1",
                     i, fword, busy, exp_f);
         end
         if (i < 8) cyc();
      end
      pulse_abort();
      n_checks++;
      if (fword !== 10'd0 || busy !== 1'b0 || done !== 1'b0 || step_tick !== 1'b0 ||
          cfg_ready !== 1'b1 || pword !== 10'd5) begin
         n_errors++;
         $display("FAIL abort_mid: got fword=%0d busy=%b done=%b tick=%b ready=%b pword=%0d, want 0 0 0 0 1 5",
                  fword, busy, done, step_tick, cfg_ready, pword);
      end
      cyc();
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_errors++;
         $display("FAIL abort_after: got busy=%b done=%b, want 0 0", busy, done);
      end
      start = 1'b1;
      abort = 1'b1;
      cyc();
      start = 1'b0;
      abort = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || fword !== 10'd0 || step_tick !== 1'b0) begin
         n_errors++;
         $display("FAIL start_abort_same: got busy=%b fword=%0d tick=%b, want 0 0 0",
                  busy, fword, step_tick);
      end
      cyc();
      n_checks++;
      if (busy !== 1'b0) begin
         n_errors++;
         $display("FAIL start_abort_hold: got busy=%b, want 0", busy);
      end
   endtask

   task automatic test_cfg_collision();
      cfg_start = 10'd7;  cfg_stop  = 10'd7;   cfg_step = 10'd1;
      cfg_dwell = 16'd0;  cfg_pword = 10'd256; cfg_loop = 1'b1;
      cfg_valid = 1'b1;
      start     = 1'b1;
      cyc();
      cfg_valid = 1'b0;
      start     = 1'b0;
      n_checks++;
      if (fword !== 10'd7 || pword !== 10'd256 || busy !== 1'b1 || step_tick !== 1'b1) begin
         n_errors++;
         $display("FAIL collision_bypass: got fword=%0d pword=%0d busy=%b tick=%b, want 7 256 1 1",
                  fword, pword, busy, step_tick);
      end
      // Config offered while busy must be refused.
      cfg_start = 10'd3; cfg_stop = 10'd50; cfg_pword = 10'd99;
      cfg_valid = 1'b1;
      n_checks++;
      if (cfg_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL busy_ready: got cfg_ready=%b, want 0", cfg_ready);
      end
      cyc();
      cfg_valid = 1'b0;
      n_checks++;
      if (pword !== 10'd256 || fword !== 10'd7 || busy !== 1'b1) begin
         n_errors++;
         $display("FAIL busy_shadow: got pword=%0d fword=%0d busy=%b, want 256 7 1",
                  pword, fword, busy);
      end
      // A start pulse during a sweep is ignored.
      pulse_start();
      n_checks++;
      if (fword !== 10'd7 || busy !== 1'b1) begin
         n_errors++;
         $display("FAIL start_while_busy: got fword=%0d busy=%b, want 7 1", fword, busy);
      end
      pulse_abort();
      // A restart from the shadow registers must still use stop=7.
      pulse_start();
      cyc();
      n_checks++;
      if (fword !== 10'd7 || pword !== 10'd256 || busy !== 1'b1 || step_tick !== 1'b1) begin
         n_errors++;
         $display("FAIL shadow_restart: got fword=%0d pword=%0d busy=%b tick=%b, want 7 256 1 1",
                  fword, pword, busy, step_tick);
      end
      pulse_abort();
   endtask

   task automatic test_async_reset();
      logic [9:0] exp_seq [5];
      exp_seq = '{10'd10, 10'd10, 10'd20, 10'd20, 10'd30};
      load_cfg(10'd10, 10'd100, 10'd10, 16'd1, 10'd3, 1'b0);
      pulse_start();
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (fword !== exp_seq[i] || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL pre_reset[%0d]: got fword=%0d busy=%b, want fword=%0d busy=1",
                     i, fword, busy, exp_seq[i]);
         end
         if (i < 4) cyc();
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({fword, pword, busy, step_tick, done, cfg_ready} !== {10'd0, 10'd0, 4'b0001}) begin
         n_errors++;
         $display("FAIL async_reset: got fword=%0d pword=%0d busy=%b tick=%b done=%b ready=%b, want 0 0 0 0 0 1",
                  fword, pword, busy, step_tick, done, cfg_ready);
      end
      rst_n = 1'b1;
      cyc();
      pulse_start();
      n_checks++;
      if (fword !== 10'd0 || pword !== 10'd0 || busy !== 1'b1 || step_tick !== 1'b1) begin
         n_errors++;
         $display("FAIL zero_cfg_start: got fword=%0d pword=%0d busy=%b tick=%b, want 0 0 1 1",
                  fword, pword, busy, step_tick);
      end
      for (int i = 0; i < 3; i++) begin
         cyc();
         n_checks++;
         if (fword !== 10'd0 || busy !== 1'b1 || step_tick !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL tone_hold[%0d]: got fword=%0d busy=%b tick=%b done=%b, want 0 1 0 0",
                     i, fword, busy, step_tick, done);
         end
      end
      pulse_abort();
   endtask

   initial begin
      rst_n     = 1'b0;
      cfg_valid = 1'b0;
      cfg_start = '0; cfg_stop = '0; cfg_step = '0;
      cfg_dwell = '0; cfg_pword = '0; cfg_loop = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      cyc();
      cyc();
      test_reset();
      test_single_sweep();
      test_no_wrap();
      test_continuous();
      test_abort();
      test_cfg_collision();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, want end before time limit");
      $fatal(1, "time limit reached");
   end

endmodule
